// File: rtl/branch_resolver.sv
// Branch resolution unit for SIMPLE-16: latches SZCV flags, evaluates branch
// conditions (holding a branch while flags are pending) and registers taken/target.
module branch_resolver #(
  parameter int ADDR_W = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        szcv_in,
  input  logic              flag_we,
  input  logic              flag_pend,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic              br_uncond,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [DISP_W-1:0] br_d,
  input  logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic [3:0]        flags
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t state, state_nxt;

  // Captured branch while waiting for its flags
  logic              uncond_p0;
  logic [2:0]        cond_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic [DISP_W-1:0] d_p0;

  // Registered result
  logic              vld_p1;
  logic              taken_p1;
  logic [ADDR_W-1:0] target_p1;

  logic [3:0]        eff_flags;
  logic              resolve;
  logic              capture;
  logic              sel_uncond;
  logic [2:0]        sel_cond;
  logic [ADDR_W-1:0] sel_pc;
  logic [DISP_W-1:0] sel_d;
  logic [3:0]        sel_f;

  function automatic logic cond_met(input logic uncond, input logic [2:0] cond,
                                    input logic s, input logic z, input logic v);
    logic r;
    if (uncond) begin
      r = 1'b1;
    end else begin
      case (cond)
        3'b000:  r = z;
        3'b001:  r = s ^ v;
        3'b010:  r = z | (s ^ v);
        3'b011:  r = ~z;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                      input logic signed [DISP_W-1:0] d);
    logic signed [ADDR_W-1:0] d_ext;
    d_ext = ADDR_W'(d);
    return pc + ADDR_W'(1) + $unsigned(d_ext);
  endfunction

  assign eff_flags = flag_we ? szcv_in : flags;
  assign br_ready  = (state == S_IDLE);

  always_comb begin
    state_nxt  = state;
    resolve    = 1'b0;
    capture    = 1'b0;
    sel_uncond = br_uncond;
    sel_cond   = br_cond;
    sel_pc     = br_pc;
    sel_d      = br_d;
    sel_f      = eff_flags;
    case (state)
      S_IDLE: begin
        if (br_valid && !flush) begin
          if (br_uncond || !flag_pend || flag_we) begin
            resolve = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        sel_uncond = uncond_p0;
        sel_cond   = cond_p0;
        sel_pc     = pc_p0;
        sel_d      = d_p0;
        sel_f      = szcv_in;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (flag_we) begin
          resolve   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= szcv_in;
    end
  end

  // Stage p0: hold the branch fields while its flags are still in flight
  always_ff @(posedge clk) begin
    if (capture) begin
      uncond_p0 <= br_uncond;
      cond_p0   <= br_cond;
      pc_p0     <= br_pc;
      d_p0      <= br_d;
    end
  end

  // Stage p1: registered result, fields held between pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else begin
      vld_p1 <= resolve;
      if (resolve) begin
        taken_p1  <= cond_met(sel_uncond, sel_cond, sel_f[3], sel_f[2], sel_f[0]);
        target_p1 <= branch_target(sel_pc, sel_d);
      end
    end
  end

  assign res_valid  = vld_p1;
  assign res_taken  = taken_p1;
  assign res_target = target_p1;

endmodule
